// File: rtl/bus_sigs_arbiter.sv
// Two-requester round-robin arbiter with a registered grant and a zero-latency output mux.
// An owner keeps the bus for at most MAX_HOLD cycles while the other side is requesting.
module bus_sigs_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_1,
  input  logic             req_2,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             gnt_1,
  output logic             gnt_2,
  output logic             sel,
  output logic [WIDTH-1:0] out_1,
  output logic             busy
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GNT_1, GNT_2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] hold_cnt, hold_nxt;
  logic          last_is_2, last_nxt;
  logic          at_max;

  assign at_max = (hold_cnt == HOLD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      last_is_2 <= 1'b1;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      last_is_2 <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = '0;
    last_nxt  = last_is_2;
    case (state)
      IDLE: begin
        if (req_1 && (!req_2 || last_is_2)) state_nxt = GNT_1;
        else if (req_2)                     state_nxt = GNT_2;
        else                                state_nxt = IDLE;
      end
      GNT_1: begin
        if (req_2 && (!req_1 || at_max)) state_nxt = GNT_2;
        else if (!req_1 && !req_2)       state_nxt = IDLE;
        else                             state_nxt = GNT_1;
      end
      GNT_2: begin
        if (req_1 && (!req_2 || at_max)) state_nxt = GNT_1;
        else if (!req_1 && !req_2)       state_nxt = IDLE;
        else                             state_nxt = GNT_2;
      end
      default: state_nxt = IDLE;
    endcase

    // Counter only advances while the same owner keeps the bus; any change restarts it.
    if (state_nxt == state && state != IDLE) begin
      hold_nxt = at_max ? hold_cnt : hold_cnt + 1'b1;
    end
    if (state_nxt != state) begin
      if (state_nxt == GNT_1) last_nxt = 1'b0;
      if (state_nxt == GNT_2) last_nxt = 1'b1;
    end
  end

  assign gnt_1 = (state == GNT_1);
  assign gnt_2 = (state == GNT_2);
  assign sel   = gnt_1;
  assign busy  = gnt_1 | gnt_2;
  assign out_1 = gnt_1 ? in_1 : (gnt_2 ? in_2 : '0);

endmodule
